serial_adder_ctrl: RTL and testbench
====================================

// Module: serial_adder_ctrl
// PURPOSE
//   Bit-serial adder sequencer. Time-multiplexes a single FULL_ADDER bit cell over a
//   WIDTH-bit operand pair, one bit per clock, LSB first.
//   Registered carry feeds back between bits. START/BUSY/DONE handshake toward a host
//   datapath that trades adder area for latency.
// PARAMETERS
//   WIDTH    8   operand/result width in bits (>=1)
//   CNT_W    $clog2(WIDTH) (min 1)   bit-counter width, derived, not overridden
// PORTS
//   CLK      in   1      single clock, all state on rising edge
//   RST      in   1      synchronous, active-high reset
//   START    in   1      request; sampled only in IDLE or FIN
//   A        in   WIDTH  operand A, captured on accepted START
//   B        in   WIDTH  operand B, captured on accepted START
//   CIN      in   1      carry-in, captured on accepted START
//   BUSY     out  1      1 while in RUN
//   DONE     out  1      one-cycle pulse, SUM/COUT/OVF newly valid
//   SUM      out  WIDTH  result, held stable until next completion
//   COUT     out  1      carry out of MSB
//   OVF      out  1      signed overflow = carry into MSB ^ carry out of MSB
// BEHAVIOUR
//   Reset: state=IDLE; BUSY=0, DONE=0, SUM=0, COUT=0, OVF=0; shift regs, carry, count = 0.
//   States: IDLE -> RUN on START; RUN -> RUN while cnt<WIDTH-1; RUN -> FIN at cnt==WIDTH-1;
//     FIN -> RUN on START, else FIN -> IDLE. FIN lasts exactly one cycle.
//   Accept (edge n, START=1, state IDLE|FIN):
//     - load ra<=A, rb<=B, cy<=CIN, cnt<=0
//     - enter RUN
//   RUN, each edge:
//     - FA(ra[0], rb[0], cy) -> s, c
//     - ra,rb shift right 1
//     - acc <= {s, acc[WIDTH-1:1]}
//     - cy <= c, cnt++
//   Last RUN edge (cnt==WIDTH-1), edge n+WIDTH:
//     - SUM <= {s, acc[WIDTH-1:1]}
//     - COUT <= c
//     - OVF <= cy ^ c
//     - enter FIN
//   Latency: DONE=1 in the cycle after edge n+WIDTH; BUSY=1 for exactly WIDTH cycles.
//   DONE is a registered state decode (state==FIN); never high two consecutive cycles
//     unless WIDTH... (n/a: min spacing is WIDTH+1 cycles).
//   SUM/COUT/OVF change only on the last RUN edge or on reset; never during RUN.
//   Arithmetic: unsigned {COUT,SUM} = A + B + CIN; sum modulo 2^WIDTH; no truncation of the carry.
//   START while RUN: ignored, no queuing; operands A/B/CIN changes during RUN have no effect.
//   START held high continuously: back-to-back ops, accepted in every FIN cycle.
//     Throughput is one result per WIDTH+1 cycles.
//   START in FIN cycle: DONE still pulses that cycle; new op enters RUN at the next edge.
//   WIDTH==1: single RUN cycle, then FIN; OVF = CIN ^ COUT-path as defined above.
//   RST mid-RUN: abort, return to IDLE next edge; all outputs cleared; no DONE for the aborted op.
//   RST has priority over START on the same edge.
// STRUCTURE
//   Shared package/include: state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_FIN=2'd2;
//     default WIDTH constant.
//   One sub-module: existing FULL_ADDER bit cell, one instance (X0=ra[0], Y0=rb[0],
//     C0=cy, S0=s, C1=c).
//   Remainder in this file: FSM, bit counter, ra/rb/acc shift registers, output registers.
//   No combinational path from inputs to outputs.
// TESTING
//   1 Reset: assert RST 3 cycles -> BUSY=0, DONE=0, SUM=0, COUT=0, OVF=0.
//     START high during RST ignored.
//   2 WIDTH=8, A=8'h3C, B=8'h5A, CIN=0, START 1 cycle
//     -> BUSY high 8 cycles, DONE pulse next cycle, SUM=8'h96, COUT=0, OVF=1.
//   3 A=8'hFF, B=8'h01, CIN=1 -> SUM=8'h01, COUT=1, OVF=0.
//     A=8'h80, B=8'h80, CIN=0 -> SUM=8'h00, COUT=1, OVF=1.
//   4 START held high 30 cycles with changing A/B
//     -> one DONE every 9 cycles; each SUM matches operands sampled at its accept edge;
//     mid-RUN changes ignored.
//   5 RST at 4th RUN cycle of A=8'h11, B=8'h22
//     -> IDLE next edge, no DONE, SUM=0.
//     Fresh START A=8'h01, B=8'h02 -> SUM=8'h03.
//   6 Random: 1000 ops at WIDTH=1, 8, 13 vs. reference model A+B+CIN,
//     checking SUM/COUT/OVF at each DONE and SUM stability between DONEs.

Source files
------------

// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder sequencer: FSM state encoding,
// default operand width and the bit-counter width helper.
package serial_adder_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    // Bit counter must index 0..width-1; a 1-bit operand still needs a 1-bit counter.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_adder_ctrl_fa.sv
// Single full-adder bit cell, time-shared by the serial adder sequencer.
module serial_adder_ctrl_fa (
    input  logic x0,
    input  logic y0,
    input  logic c0,
    output logic s0,
    output logic c1
);

    assign s0 = x0 ^ y0 ^ c0;
    assign c1 = (x0 & y0) | (c0 & (x0 ^ y0));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: one full-adder cell walks a WIDTH-bit operand
// pair LSB first, one bit per clock, with a registered carry between bits.
// START/BUSY/DONE handshake; results are held until the next completion.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int               CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic             cy;
    logic [CNT_W-1:0] cnt;
    logic             s;
    logic             c;
    logic [WIDTH-1:0] result;
    logic             last_bit;

    serial_adder_ctrl_fa u_fa (
        .x0 (ra[0]),
        .y0 (rb[0]),
        .c0 (cy),
        .s0 (s),
        .c1 (c)
    );

    assign last_bit = (state == ST_RUN) && (cnt == LAST_CNT);
    assign busy     = (state == ST_RUN);
    assign done     = (state == ST_FIN);

    // State register; reset wins over any start request on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode: START is only honoured in IDLE or FIN, FIN lasts one cycle.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (start) next_state = ST_RUN;
            ST_RUN:  if (cnt == LAST_CNT) next_state = ST_FIN;
            ST_FIN:  next_state = start ? ST_RUN : ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // The partial-sum shift register only needs the WIDTH-1 bits that survive
    // into the final result; the newest bit comes straight from the adder cell.
    generate
        if (WIDTH == 1) begin : g_single
            assign result = s;
        end else begin : g_multi
            logic [WIDTH-2:0] hi;

            // Shift each new sum bit in from the top while running.
            always_ff @(posedge clk) begin
                if (rst) begin
                    hi <= '0;
                end else if (state == ST_RUN) begin
                    hi <= result[WIDTH-1:1];
                end
            end

            assign result = {s, hi};
        end
    endgenerate

    // Operand capture on accept, per-bit shifting and carry/counter update in
    // RUN, and result registers loaded only on the final bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            ra   <= '0;
            rb   <= '0;
            cy   <= 1'b0;
            cnt  <= '0;
            sum  <= '0;
            cout <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_FIN: begin
                    if (start) begin
                        ra  <= a;
                        rb  <= b;
                        cy  <= cin;
                        cnt <= '0;
                    end
                end
                ST_RUN: begin
                    ra  <= ra >> 1;
                    rb  <= rb >> 1;
                    cy  <= c;
                    cnt <= cnt + CNT_W'(1);
                    if (last_bit) begin
                        sum  <= result;
                        cout <= c;
                        ovf  <= cy ^ c;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Testbench for serial_adder_ctrl: three instances (WIDTH 1, 8, 13) share one
// clock and reset. A cycle-level behavioural model built from plain integer
// arithmetic predicts BUSY/DONE/SUM/COUT/OVF every cycle; directed scenarios
// run on the 8-bit instance, then all three run randomized traffic.
module tb_serial_adder_ctrl;

    localparam int N_DUT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        start  [N_DUT];
    logic [12:0] a_in   [N_DUT];
    logic [12:0] b_in   [N_DUT];
    logic        cin_in [N_DUT];

    logic        busy_w1, done_w1, cout_w1, ovf_w1;
    logic [0:0]  sum_w1;
    logic        busy_w8, done_w8, cout_w8, ovf_w8;
    logic [7:0]  sum_w8;
    logic        busy_w13, done_w13, cout_w13, ovf_w13;
    logic [12:0] sum_w13;

    logic        obs_busy [N_DUT];
    logic        obs_done [N_DUT];
    logic        obs_cout [N_DUT];
    logic        obs_ovf  [N_DUT];
    logic [12:0] obs_sum  [N_DUT];

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Behavioural model state per instance
    int              m_left     [N_DUT];
    bit              m_fin      [N_DUT];
    longint unsigned m_sum      [N_DUT];
    bit              m_cout     [N_DUT];
    bit              m_ovf      [N_DUT];
    longint unsigned p_sum      [N_DUT];
    bit              p_cout     [N_DUT];
    bit              p_ovf      [N_DUT];
    int              m_done_cnt [N_DUT];

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(1)) dut_w1 (
        .clk(clk), .rst(rst), .start(start[0]),
        .a(a_in[0][0:0]), .b(b_in[0][0:0]), .cin(cin_in[0]),
        .busy(busy_w1), .done(done_w1), .sum(sum_w1), .cout(cout_w1), .ovf(ovf_w1)
    );

    serial_adder_ctrl #(.WIDTH(8)) dut_w8 (
        .clk(clk), .rst(rst), .start(start[1]),
        .a(a_in[1][7:0]), .b(b_in[1][7:0]), .cin(cin_in[1]),
        .busy(busy_w8), .done(done_w8), .sum(sum_w8), .cout(cout_w8), .ovf(ovf_w8)
    );

    serial_adder_ctrl #(.WIDTH(13)) dut_w13 (
        .clk(clk), .rst(rst), .start(start[2]),
        .a(a_in[2]), .b(b_in[2]), .cin(cin_in[2]),
        .busy(busy_w13), .done(done_w13), .sum(sum_w13), .cout(cout_w13), .ovf(ovf_w13)
    );

    // Gather the three instances' outputs into indexable arrays.
    always_comb begin
        obs_busy[0] = busy_w1;  obs_done[0] = done_w1;  obs_cout[0] = cout_w1;  obs_ovf[0] = ovf_w1;
        obs_sum[0]  = {12'b0, sum_w1};
        obs_busy[1] = busy_w8;  obs_done[1] = done_w8;  obs_cout[1] = cout_w8;  obs_ovf[1] = ovf_w8;
        obs_sum[1]  = {5'b0, sum_w8};
        obs_busy[2] = busy_w13; obs_done[2] = done_w13; obs_cout[2] = cout_w13; obs_ovf[2] = ovf_w13;
        obs_sum[2]  = sum_w13;
    end

    function automatic int width_of(input int i);
        case (i)
            0:       return 1;
            1:       return 8;
            default: return 13;
        endcase
    endfunction

    // Reference arithmetic: unsigned sum with carry-out, signed-range overflow.
    function automatic void ref_add(input int w, input longint unsigned av, input longint unsigned bv,
                                    input bit ci, output longint unsigned s, output bit co, output bit ov);
        longint unsigned full;
        longint unsigned half;
        longint unsigned total;
        longint          sa;
        longint          sb;
        longint          ss;
        full  = 64'd1 << w;
        half  = 64'd1 << (w - 1);
        total = av + bv + 64'(ci);
        s     = total % full;
        co    = (total >= full);
        sa    = longint'(av);
        if (av >= half) sa = sa - longint'(full);
        sb    = longint'(bv);
        if (bv >= half) sb = sb - longint'(full);
        ss    = sa + sb;
        if (ci) ss = ss + 1;
        ov    = (ss >= longint'(half)) || (ss < -longint'(half));
    endfunction

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Advance the model by one rising edge using the inputs presented to it.
    task automatic model_update(input int i);
        int              w;
        longint unsigned mask;
        w    = width_of(i);
        mask = (64'd1 << w) - 64'd1;
        if (rst) begin
            m_left[i] = 0;
            m_fin[i]  = 1'b0;
            m_sum[i]  = 0;
            m_cout[i] = 1'b0;
            m_ovf[i]  = 1'b0;
        end else if (m_left[i] > 0) begin
            m_left[i]--;
            if (m_left[i] == 0) begin
                m_fin[i]  = 1'b1;
                m_sum[i]  = p_sum[i];
                m_cout[i] = p_cout[i];
                m_ovf[i]  = p_ovf[i];
                m_done_cnt[i]++;
            end
        end else begin
            m_fin[i] = 1'b0;
            if (start[i]) begin
                ref_add(w, 64'(a_in[i]) & mask, 64'(b_in[i]) & mask, cin_in[i],
                        p_sum[i], p_cout[i], p_ovf[i]);
                m_left[i] = w;
            end
        end
    endtask

    // One clock: update the model at the edge, compare every instance at the falling edge.
    task automatic step();
        @(posedge clk);
        for (int i = 0; i < N_DUT; i++) model_update(i);
        @(negedge clk);
        if (chk_en) begin
            for (int i = 0; i < N_DUT; i++) begin
                check_output($sformatf("w%0d.busy", width_of(i)), 64'(obs_busy[i]), 64'(m_left[i] > 0));
                check_output($sformatf("w%0d.done", width_of(i)), 64'(obs_done[i]), 64'(m_fin[i]));
                check_output($sformatf("w%0d.sum",  width_of(i)), 64'(obs_sum[i]),  m_sum[i]);
                check_output($sformatf("w%0d.cout", width_of(i)), 64'(obs_cout[i]), 64'(m_cout[i]));
                check_output($sformatf("w%0d.ovf",  width_of(i)), 64'(obs_ovf[i]),  64'(m_ovf[i]));
            end
        end
    endtask

    // Single operation on the 8-bit instance with fixed expected results.
    task automatic apply_stimulus(input logic [7:0] av, input logic [7:0] bv, input logic ci,
                                  input logic [7:0] es, input logic ec, input logic eo, input string name);
        int busy_cycles;
        bit seen;
        busy_cycles = 0;
        seen        = 1'b0;
        start[1]  = 1'b1;
        a_in[1]   = {5'b0, av};
        b_in[1]   = {5'b0, bv};
        cin_in[1] = ci;
        step();
        start[1]  = 1'b0;
        a_in[1]   = 13'($urandom);
        b_in[1]   = 13'($urandom);
        cin_in[1] = 1'($urandom);
        if (obs_busy[1]) busy_cycles++;
        for (int k = 0; k < 20 && !seen; k++) begin
            step();
            if (obs_done[1]) seen = 1'b1;
            else if (obs_busy[1]) busy_cycles++;
        end
        check_output({name, ".done_seen"}, 64'(seen), 64'd1);
        check_output({name, ".busy_cycles"}, 64'(busy_cycles), 64'd8);
        check_output({name, ".sum"}, 64'(obs_sum[1]), 64'(es));
        check_output({name, ".cout"}, 64'(obs_cout[1]), 64'(ec));
        check_output({name, ".ovf"}, 64'(obs_ovf[1]), 64'(eo));
        step();
        check_output({name, ".done_drop"}, 64'(obs_done[1]), 64'd0);
    endtask

    initial begin
        int n_done;
        int last_done;
        int base_cnt [N_DUT];
        bit all_done;

        rst = 1'b1;
        for (int i = 0; i < N_DUT; i++) begin
            start[i] = 1'b1; a_in[i] = '1; b_in[i] = '1; cin_in[i] = 1'b1;
        end

        $display("[TB] reset with start held high");
        step();
        chk_en = 1'b1;
        step();
        step();
        check_output("reset.busy", 64'(obs_busy[1]), 64'd0);
        check_output("reset.done", 64'(obs_done[1]), 64'd0);
        check_output("reset.sum",  64'(obs_sum[1]),  64'd0);
        check_output("reset.cout", 64'(obs_cout[1]), 64'd0);
        check_output("reset.ovf",  64'(obs_ovf[1]),  64'd0);
        rst = 1'b0;
        for (int i = 0; i < N_DUT; i++) start[i] = 1'b0;
        step();
        check_output("reset.idle_after", 64'(obs_busy[1]), 64'd0);

        $display("[TB] directed operations");
        apply_stimulus(8'h3C, 8'h5A, 1'b0, 8'h96, 1'b0, 1'b1, "t2");
        apply_stimulus(8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0, "t3a");
        apply_stimulus(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, "t3b");

        $display("[TB] start held high for 30 cycles");
        n_done    = 0;
        last_done = -1;
        for (int k = 1; k <= 30; k++) begin
            start[1]  = 1'b1;
            a_in[1]   = 13'($urandom);
            b_in[1]   = 13'($urandom);
            cin_in[1] = 1'($urandom);
            step();
            if (obs_done[1]) begin
                n_done++;
                if (last_done > 0) check_output("t4.spacing", 64'(k - last_done), 64'd9);
                last_done = k;
            end
        end
        check_output("t4.done_count", 64'(n_done), 64'd3);
        start[1] = 1'b0;
        for (int k = 0; k < 12; k++) step();

        $display("[TB] reset during run");
        start[1]  = 1'b1;
        a_in[1]   = 13'h11;
        b_in[1]   = 13'h22;
        cin_in[1] = 1'b0;
        step();
        start[1] = 1'b0;
        for (int k = 0; k < 3; k++) step();
        check_output("t5.busy_before_rst", 64'(obs_busy[1]), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_output("t5.busy_after_rst", 64'(obs_busy[1]), 64'd0);
        check_output("t5.sum_after_rst",  64'(obs_sum[1]),  64'd0);
        n_done = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (obs_done[1]) n_done++;
        end
        check_output("t5.no_done", 64'(n_done), 64'd0);
        apply_stimulus(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0, "t5.fresh");

        $display("[TB] randomized traffic on all widths");
        for (int i = 0; i < N_DUT; i++) base_cnt[i] = m_done_cnt[i];
        all_done = 1'b0;
        for (int cyc = 0; cyc < 30000 && !all_done; cyc++) begin
            rst = ($urandom_range(0, 1999) == 0);
            for (int i = 0; i < N_DUT; i++) begin
                start[i]  = ($urandom_range(0, 9) < 7);
                a_in[i]   = 13'($urandom);
                b_in[i]   = 13'($urandom);
                cin_in[i] = 1'($urandom);
            end
            step();
            all_done = 1'b1;
            for (int i = 0; i < N_DUT; i++)
                if (m_done_cnt[i] - base_cnt[i] < 1000) all_done = 1'b0;
        end
        rst = 1'b0;
        for (int i = 0; i < N_DUT; i++) start[i] = 1'b0;
        for (int k = 0; k < 16; k++) step();
        for (int i = 0; i < N_DUT; i++)
            check_output($sformatf("rand.w%0d.ops_reached", width_of(i)),
                         64'(m_done_cnt[i] - base_cnt[i] >= 1000), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
